psum_writeback: RTL

//  Drain side of the corelet datapath: pops one col-lane psum vector per output pixel from the

---
 rtl/corelet_pkg.sv | 23 ++
 rtl/psum_add_lane.sv | 19 +
 rtl/psum_writeback.sv | 127 ++++++++++++
 3 files changed

// File: rtl/corelet_pkg.sv
// Shared corelet definitions: datapath geometry, psum vector type and writeback FSM states.
package corelet_pkg;

    localparam int unsigned Col    = 8;
    localparam int unsigned PsumBw = 16;
    localparam int unsigned NPix   = 16;
    localparam int unsigned NKij   = 9;
    localparam int unsigned Aw     = 7;
    localparam int unsigned KijW   = 4;
    localparam int unsigned PixW   = $clog2(NPix);

    typedef logic [Col*PsumBw-1:0] psum_vec_t;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRd,
        StRdw,
        StWr,
        StDone
    } wb_state_e;

endpackage

// File: rtl/psum_add_lane.sv
// One psum lane: wrapping signed add of new partial sum onto stored sum, optional ReLU clamp.
module psum_add_lane
    import corelet_pkg::*;
(
    input  logic [PsumBw-1:0] a,
    input  logic [PsumBw-1:0] b,
    input  logic              clear_b,
    input  logic              relu,
    output logic [PsumBw-1:0] sum
);

    logic [PsumBw-1:0] raw;

    always_comb begin
        raw = a + (clear_b ? '0 : b);
        sum = (relu && raw[PsumBw-1]) ? '0 : raw;
    end

endmodule

// File: rtl/psum_writeback.sv
// OFIFO -> psum SRAM read-modify-write accumulator, one pass per kernel position.
// Define PSUM_WB_RELU_EN to clamp negative lanes to zero on the final pass.
module psum_writeback
    import corelet_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [KijW-1:0] kij,
    input  logic [Aw-1:0]   base_addr,
    input  psum_vec_t       ofifo_out,
    input  logic            ofifo_valid,
    output logic            ofifo_rd,
    input  psum_vec_t       O_Q,
    output psum_vec_t       O_D,
    output logic [Aw-1:0]   O_A,
    output logic            O_CEN,
    output logic            O_WEN,
    output logic            busy,
    output logic            done
);

    wb_state_e       state_q;
    logic [PixW-1:0] pix_q;
    logic [KijW-1:0] kij_q;
    logic [Aw-1:0]   base_q;
    psum_vec_t       hold_q;

    logic            kij_zero;
    logic            relu_en;
    logic [Aw-1:0]   addr_next;
    psum_vec_t       add_a;
    psum_vec_t       sum_vec;

    assign kij_zero  = (kij_q == '0);
    assign addr_next = base_q + Aw'(pix_q);
    // The kij==0 write is formed directly from the OFIFO head as it is popped.
    assign add_a     = (state_q == StWait) ? ofifo_out : hold_q;
    assign ofifo_rd  = (state_q == StWait) && ofifo_valid;

`ifdef PSUM_WB_RELU_EN
    assign relu_en = (kij_q == KijW'(NKij - 1));
`else
    assign relu_en = 1'b0;
`endif

    for (genvar i = 0; i < Col; i++) begin : g_lane
        psum_add_lane u_lane (
            .a       (add_a[i*PsumBw +: PsumBw]),
            .b       (O_Q[i*PsumBw +: PsumBw]),
            .clear_b (kij_zero),
            .relu    (relu_en),
            .sum     (sum_vec[i*PsumBw +: PsumBw])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pix_q   <= '0;
            kij_q   <= '0;
            base_q  <= '0;
            hold_q  <= '0;
            O_CEN   <= 1'b1;
            O_WEN   <= 1'b1;
            O_A     <= '0;
            O_D     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        kij_q   <= kij;
                        base_q  <= base_addr;
                        pix_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (ofifo_valid) begin
                        hold_q <= ofifo_out;
                        O_CEN  <= 1'b0;
                        O_A    <= addr_next;
                        if (kij_zero) begin
                            O_WEN   <= 1'b0;
                            O_D     <= sum_vec;
                            state_q <= StWr;
                        end else begin
                            O_WEN   <= 1'b1;
                            state_q <= StRd;
                        end
                    end
                end
                StRd: begin
                    O_CEN   <= 1'b1;
                    state_q <= StRdw;
                end
                StRdw: begin
                    O_CEN   <= 1'b0;
                    O_WEN   <= 1'b0;
                    O_D     <= sum_vec;
                    state_q <= StWr;
                end
                StWr: begin
                    O_CEN <= 1'b1;
                    O_WEN <= 1'b1;
                    if (pix_q == PixW'(NPix - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        pix_q   <= pix_q + PixW'(1);
                        state_q <= StWait;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
